ex_stage_unit: RTL and testbench

//  EX stage of the 5-stage MIPS pipeline, directly downstream of id_ex_decoder. Consumes ALU opcode and

---
 rtl/ex_stage_if.sv | 47 ++++
 rtl/ex_stage_unit.sv | 170 +++++++++++++++++
 tb/tb_ex_stage_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Bundle between the ID/EX front end and the EX stage: operands and control in,
// EX/MEM pipeline register and CP0 exception request out.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            flush_i;
  logic            in_valid;
  logic [4:0]      alu_op;
  logic            ovf_chk;
  logic            cp0_sel;
  logic            syscall_i;
  logic            eret_i;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] cp0_data;
  logic [XLEN-1:0] pc_i;
  logic [4:0]      rd_i;
  logic            reg_we_i;
  logic [3:0]      mem_ctl_i;

  logic            exmem_valid;
  logic [XLEN-1:0] exmem_result;
  logic [4:0]      exmem_rd;
  logic            exmem_we;
  logic [3:0]      exmem_mem_ctl;
  logic [XLEN-1:0] exmem_pc;
  logic            exmem_br;
  logic            exmem_eret;
  logic            exc_req;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] exc_epc;

  modport master (
    output stall_i, flush_i, in_valid, alu_op, ovf_chk, cp0_sel, syscall_i, eret_i,
           op_a, op_b, cp0_data, pc_i, rd_i, reg_we_i, mem_ctl_i,
    input  exmem_valid, exmem_result, exmem_rd, exmem_we, exmem_mem_ctl, exmem_pc,
           exmem_br, exmem_eret, exc_req, exc_code, exc_epc
  );

  modport slave (
    input  stall_i, flush_i, in_valid, alu_op, ovf_chk, cp0_sel, syscall_i, eret_i,
           op_a, op_b, cp0_data, pc_i, rd_i, reg_we_i, mem_ctl_i,
    output exmem_valid, exmem_result, exmem_rd, exmem_we, exmem_mem_ctl, exmem_pc,
           exmem_br, exmem_eret, exc_req, exc_code, exc_epc
  );
endinterface

// File: rtl/ex_stage_unit.sv
// MIPS EX stage: ALU, branch compare and overflow detect feeding the EX/MEM register,
// with a RUN/EXC_WAIT FSM that requests CP0 exceptions and squashes ops until flush.
module ex_stage_unit #(
  parameter int         XLEN    = 32,
  parameter logic [4:0] EXC_OV  = 5'h0C,
  parameter logic [4:0] EXC_SYS = 5'h08
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_stage_if.slave   ex_if
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3,  OP_OR   = 5'd4,
    OP_XOR  = 5'd5,  OP_NOR  = 5'd6,  OP_SLT  = 5'd7,  OP_SLTU = 5'd8,
    OP_SLL  = 5'd9,  OP_SRL  = 5'd10, OP_SRA  = 5'd11, OP_BEQ  = 5'd12,
    OP_BNE  = 5'd13, OP_BGEZ = 5'd14, OP_BGTZ = 5'd15, OP_BLEZ = 5'd16,
    OP_BLTZ = 5'd17, OP_LUI  = 5'd18
  } alu_op_e;

  typedef enum logic {
    ST_RUN,
    ST_EXC_WAIT
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            we;
    logic [3:0]      mem_ctl;
    logic [XLEN-1:0] pc;
    logic            br;
    logic            eret;
  } exmem_t;

  localparam int MSB = XLEN - 1;

  alu_op_e         op;
  logic [XLEN-1:0] a, b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] sum, diff;
  logic            add_ovf, sub_ovf;
  logic [XLEN-1:0] alu_res;
  logic            br_taken;
  logic            ovf;
  logic            fault;

  assign op    = alu_op_e'(ex_if.alu_op);
  assign a     = ex_if.op_a;
  assign b     = ex_if.op_b;
  assign shamt = a[4:0];
  assign sum   = a + b;
  assign diff  = a - b;

  // Signed overflow: add overflows when like-signed operands give a differently signed sum;
  // sub overflows when unlike-signed operands give a result whose sign differs from op_a.
  assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB]  != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    alu_res  = '0;
    br_taken = 1'b0;
    unique case (op)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(b) >>> shamt);
      OP_LUI:  alu_res = b << 16;
      OP_BEQ:  br_taken = (a == b);
      OP_BNE:  br_taken = (a != b);
      OP_BGEZ: br_taken = !a[MSB];
      OP_BGTZ: br_taken = !a[MSB] && (a != '0);
      OP_BLEZ: br_taken = a[MSB] || (a == '0);
      OP_BLTZ: br_taken = a[MSB];
      default: ;
    endcase
    if (ex_if.cp0_sel) begin
      alu_res = ex_if.cp0_data;
    end
  end

  assign ovf   = ex_if.ovf_chk && (((op == OP_ADD) && add_ovf) || ((op == OP_SUB) && sub_ovf));
  assign fault = ex_if.in_valid && (ovf || ex_if.syscall_i);

  state_e          state_q, state_d;
  exmem_t          exmem_q, exmem_d;
  logic            exc_req_q, exc_req_d;
  logic [4:0]      exc_code_q, exc_code_d;
  logic [XLEN-1:0] exc_epc_q, exc_epc_d;

  always_comb begin
    state_d    = state_q;
    exmem_d    = exmem_q;
    exc_req_d  = 1'b0;
    exc_code_d = exc_code_q;
    exc_epc_d  = exc_epc_q;

    if (ex_if.flush_i) begin
      exmem_d.valid   = 1'b0;
      exmem_d.we      = 1'b0;
      exmem_d.br      = 1'b0;
      exmem_d.eret    = 1'b0;
      exmem_d.mem_ctl = '0;
      state_d         = ST_RUN;
    end else if (!ex_if.stall_i) begin
      // Bubble first; only a clean op in RUN is allowed to fill the register.
      exmem_d.valid   = 1'b0;
      exmem_d.we      = 1'b0;
      exmem_d.br      = 1'b0;
      exmem_d.eret    = 1'b0;
      exmem_d.mem_ctl = '0;
      if (state_q == ST_RUN) begin
        if (fault) begin
          exc_req_d  = 1'b1;
          exc_code_d = ovf ? EXC_OV : EXC_SYS;
          exc_epc_d  = ex_if.pc_i;
          state_d    = ST_EXC_WAIT;
        end else begin
          exmem_d.valid   = ex_if.in_valid;
          exmem_d.result  = alu_res;
          exmem_d.rd      = ex_if.rd_i;
          exmem_d.pc      = ex_if.pc_i;
          exmem_d.we      = ex_if.in_valid && ex_if.reg_we_i;
          exmem_d.br      = ex_if.in_valid && br_taken;
          exmem_d.eret    = ex_if.in_valid && ex_if.eret_i;
          exmem_d.mem_ctl = ex_if.in_valid ? ex_if.mem_ctl_i : 4'h0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      exmem_q    <= '0;
      exc_req_q  <= 1'b0;
      exc_code_q <= '0;
      exc_epc_q  <= '0;
    end else begin
      state_q    <= state_d;
      exmem_q    <= exmem_d;
      exc_req_q  <= exc_req_d;
      exc_code_q <= exc_code_d;
      exc_epc_q  <= exc_epc_d;
    end
  end

  assign ex_if.exmem_valid   = exmem_q.valid;
  assign ex_if.exmem_result  = exmem_q.result;
  assign ex_if.exmem_rd      = exmem_q.rd;
  assign ex_if.exmem_we      = exmem_q.we;
  assign ex_if.exmem_mem_ctl = exmem_q.mem_ctl;
  assign ex_if.exmem_pc      = exmem_q.pc;
  assign ex_if.exmem_br      = exmem_q.br;
  assign ex_if.exmem_eret    = exmem_q.eret;
  assign ex_if.exc_req       = exc_req_q;
  assign ex_if.exc_code      = exc_code_q;
  assign ex_if.exc_epc       = exc_epc_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Self-checking bench for ex_stage_unit: directed corner cases followed by random
// traffic, compared each cycle against an arithmetic reference of the EX stage.
module tb_ex_stage_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_stage_if #(.XLEN(32)) bus ();

  ex_stage_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex_if (bus)
  );

  typedef struct {
    bit          stall, flush, valid, ovf_chk, cp0_sel, sys, eret, we;
    logic [4:0]  op;
    logic [31:0] a, b, cp0, pc;
    logic [4:0]  rd;
    logic [3:0]  mem;
  } stim_t;

  // Reference state
  bit          m_valid, m_we, m_br, m_eret, m_exc_req, m_in_exc;
  logic [31:0] m_result, m_pc, m_epc;
  logic [4:0]  m_rd, m_code;
  logic [3:0]  m_mem;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;
  logic [31:0] pc_ctr = 32'h0040_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Result, branch decision and overflow from the ISA definition using wide arithmetic.
  task automatic ref_eval(input stim_t s, output logic [31:0] res, output bit taken, output bit ovf);
    longint sa, sb, wide;
    sa = longint'($signed(s.a));
    sb = longint'($signed(s.b));
    res = 32'h0; taken = 0; ovf = 0;
    case (s.op)
      5'd1, 5'd2: begin
        wide = (s.op == 5'd1) ? sa + sb : sa - sb;
        res  = wide[31:0];
        ovf  = s.ovf_chk && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
      end
      5'd3:  res = s.a & s.b;
      5'd4:  res = s.a | s.b;
      5'd5:  res = s.a ^ s.b;
      5'd6:  res = ~(s.a | s.b);
      5'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
      5'd8:  res = (s.a < s.b) ? 32'd1 : 32'd0;
      5'd9:  res = s.b << s.a[4:0];
      5'd10: res = s.b >> s.a[4:0];
      5'd11: res = 32'(sb >>> s.a[4:0]);
      5'd18: res = {s.b[15:0], 16'h0000};
      5'd12: taken = (s.a == s.b);
      5'd13: taken = (s.a != s.b);
      5'd14: taken = (sa >= 0);
      5'd15: taken = (sa > 0);
      5'd16: taken = (sa <= 0);
      5'd17: taken = (sa < 0);
      default: ;
    endcase
    if (s.cp0_sel) res = s.cp0;
  endtask

  task automatic model_bubble();
    m_valid = 0; m_we = 0; m_br = 0; m_eret = 0; m_mem = 4'h0;
  endtask

  task automatic model_reset();
    model_bubble();
    m_result = '0; m_pc = '0; m_rd = '0;
    m_exc_req = 0; m_in_exc = 0; m_code = '0; m_epc = '0;
  endtask

  task automatic model_step(input stim_t s);
    logic [31:0] res;
    bit taken, ovf;
    ref_eval(s, res, taken, ovf);
    m_exc_req = 0;
    if (s.flush) begin
      model_bubble();
      m_in_exc = 0;
    end else if (s.stall) begin
      // pipeline register frozen
    end else if (m_in_exc) begin
      model_bubble();
    end else if (s.valid && (ovf || s.sys)) begin
      model_bubble();
      m_exc_req = 1;
      m_code    = ovf ? 5'h0C : 5'h08;
      m_epc     = s.pc;
      m_in_exc  = 1;
    end else begin
      m_valid  = s.valid;
      m_result = res;
      m_rd     = s.rd;
      m_pc     = s.pc;
      m_we     = s.valid && s.we;
      m_br     = s.valid && taken;
      m_eret   = s.valid && s.eret;
      m_mem    = s.valid ? s.mem : 4'h0;
    end
  endtask

  task automatic compare();
    check("exmem_valid", 32'(bus.exmem_valid), 32'(m_valid));
    check("exmem_we",    32'(bus.exmem_we),    32'(m_we));
    check("exmem_br",    32'(bus.exmem_br),    32'(m_br));
    check("exmem_eret",  32'(bus.exmem_eret),  32'(m_eret));
    check("exmem_mem",   32'(bus.exmem_mem_ctl), 32'(m_mem));
    check("exc_req",     32'(bus.exc_req),     32'(m_exc_req));
    check("exc_code",    32'(bus.exc_code),    32'(m_code));
    check("exc_epc",     bus.exc_epc,          m_epc);
    if (m_valid) begin
      check("exmem_result", bus.exmem_result, m_result);
      check("exmem_rd",     32'(bus.exmem_rd), 32'(m_rd));
      check("exmem_pc",     bus.exmem_pc,     m_pc);
    end
    if (bus.exc_req === 1'b1) pulses++;
  endtask

  task automatic drive(input stim_t s);
    bus.stall_i   = s.stall;   bus.flush_i  = s.flush;  bus.in_valid  = s.valid;
    bus.alu_op    = s.op;      bus.ovf_chk  = s.ovf_chk; bus.cp0_sel  = s.cp0_sel;
    bus.syscall_i = s.sys;     bus.eret_i   = s.eret;   bus.op_a      = s.a;
    bus.op_b      = s.b;       bus.cp0_data = s.cp0;    bus.pc_i      = s.pc;
    bus.rd_i      = s.rd;      bus.reg_we_i = s.we;     bus.mem_ctl_i = s.mem;
  endtask

  task automatic step(input stim_t s);
    drive(s);
    @(posedge clk);
    #1;
    cyc++;
    model_step(s);
    compare();
  endtask

  function automatic stim_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    stim_t s;
    s = '{default: '0};
    s.valid = 1; s.we = 1; s.op = op; s.a = a; s.b = b;
    s.rd = 5'd9; s.mem = 4'h3; s.cp0 = 32'hC0C0_0001;
    pc_ctr += 4;
    s.pc = pc_ctr;
    return s;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0;
      4: return 32'(int'($urandom_range(0, 40)));
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s = mk(5'($urandom_range(0, 20)), rnd_operand(), rnd_operand());
    s.valid   = ($urandom_range(0, 7) != 0);
    s.ovf_chk = $urandom_range(0, 1) == 1;
    s.cp0_sel = ($urandom_range(0, 9) == 0);
    s.sys     = ($urandom_range(0, 19) == 0);
    s.eret    = ($urandom_range(0, 9) == 0);
    s.we      = $urandom_range(0, 3) != 0;
    s.rd      = 5'($urandom);
    s.mem     = 4'($urandom);
    s.cp0     = $urandom;
    s.stall   = ($urandom_range(0, 5) == 0);
    s.flush   = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    stim_t s;
    int    p0;
    drive('{default: '0});
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare();
    rst_n = 1'b1;

    // Overflowing add with trap: one pulse, code 0x0C, faulting op never writes
    s = mk(5'd1, 32'h7FFF_FFFF, 32'h1); s.ovf_chk = 1;
    p0 = pulses;
    step(s);
    check("ovf_req", 32'(bus.exc_req), 32'd1);
    check("ovf_code", 32'(bus.exc_code), 32'h0C);
    check("ovf_epc", bus.exc_epc, s.pc);
    check("ovf_we", 32'(bus.exmem_we), 32'd0);
    step(mk(5'd3, 32'h1, 32'h1));
    check("ovf_pulse_count", 32'(pulses - p0), 32'd1);
    s = mk(5'd0, 0, 0); s.flush = 1; step(s);

    // Same add without trap wraps
    step(mk(5'd1, 32'h7FFF_FFFF, 32'h1));
    check("addu_wrap", bus.exmem_result, 32'h8000_0000);
    check("addu_we", 32'(bus.exmem_we), 32'd1);
    step(mk(5'd11, 32'd4, 32'h8000_0000));
    check("sra", bus.exmem_result, 32'hF800_0000);
    step(mk(5'd7, 32'hFFFF_FFFF, 32'd1));
    check("slt", bus.exmem_result, 32'd1);
    step(mk(5'd8, 32'hFFFF_FFFF, 32'd1));
    check("sltu", bus.exmem_result, 32'd0);
    step(mk(5'd18, 32'd0, 32'h1234));
    check("lui", bus.exmem_result, 32'h1234_0000);
    step(mk(5'd12, 32'd5, 32'd5));
    check("beq", 32'(bus.exmem_br), 32'd1);
    step(mk(5'd17, 32'd0, 32'd0));
    check("bltz", 32'(bus.exmem_br), 32'd0);
    step(mk(5'd15, 32'd1, 32'd0));
    check("bgtz", 32'(bus.exmem_br), 32'd1);

    // Syscall followed by adds: single request, adds squashed until flush
    p0 = pulses;
    s = mk(5'd0, 0, 0); s.sys = 1; step(s);
    check("sys_code", 32'(bus.exc_code), 32'h08);
    for (int i = 0; i < 3; i++) begin
      step(mk(5'd1, 32'(i), 32'd2));
      check("sys_squash", 32'(bus.exmem_valid), 32'd0);
    end
    check("sys_pulse_count", 32'(pulses - p0), 32'd1);
    s = mk(5'd0, 0, 0); s.flush = 1; step(s);
    step(mk(5'd1, 32'd3, 32'd4));
    check("resume", bus.exmem_result, 32'd7);

    // Overflow held by stall: no request until released
    p0 = pulses;
    s = mk(5'd2, 32'h8000_0000, 32'h1); s.ovf_chk = 1; s.stall = 1;
    step(s); step(s);
    check("stall_no_req", 32'(pulses - p0), 32'd0);
    s.stall = 0; step(s);
    check("stall_release_req", 32'(bus.exc_req), 32'd1);
    s = mk(5'd0, 0, 0); s.flush = 1; step(s);

    // Flush in the same cycle as a fault wins
    s = mk(5'd1, 32'h8000_0000, 32'h8000_0000); s.ovf_chk = 1; s.flush = 1;
    step(s);
    check("flush_fault_req", 32'(bus.exc_req), 32'd0);
    check("flush_fault_valid", 32'(bus.exmem_valid), 32'd0);

    // Random traffic with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      step(rnd_stim());
      if (i == 200) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
